io_port_bank: RTL and testbench
===============================

Name: io_port_bank

Overview:
- Parametrised I/O port bank for the RISC processor top level, addressed by a port_id and driven by the processor's write_strobe/read_strobe.
- Provides N_IN synchronised input channels (switches, buttons) and N_OUT latched output channels (LEDs, displays).
- Adds per-input change detection with a maskable interrupt line.
- Replaces ad-hoc single sw/led registers with one addressed, reset-clean block.

Parameters:
- DATA_W, 8, width of each channel and of the processor data bus
- N_IN, 2, number of input channels; 1 <= N_IN <= DATA_W and N_IN <= 2^PORT_ID_W - 2
- N_OUT, 2, number of output channels; 1 <= N_OUT <= 2^PORT_ID_W - 2
- SYNC_STAGES, 2, flops in each input synchroniser chain; minimum 2
- PORT_ID_W, 4, width of port_id

Ports:
- clk, input, 1, sole clock; all logic on rising edge
- rst, input, 1, synchronous, active-high reset
- port_id, input, PORT_ID_W, register address for the current strobe
- write_strobe, input, 1, one-cycle write request
- read_strobe, input, 1, one-cycle read request
- wr_data, input, DATA_W, processor write data
- rd_data, output, DATA_W, registered read data
- rd_valid, output, 1, high for exactly one cycle when rd_data is valid
- in_pins, input, N_IN*DATA_W, asynchronous inputs; channel i is bits [i*DATA_W +: DATA_W]
- out_pins, output, N_OUT*DATA_W, latched outputs; same packing as in_pins
- irq, output, 1, level interrupt, high while any unmasked change flag is set

Behaviour:
- Reset: one clock, synchronous, active-high. While rst is sampled high, all of the following clear to 0, and rst overrides any strobe in the same cycle:
  - out_pins, rd_data, rd_valid, irq
  - all synchroniser flops
  - chg flags, irq mask
- Address map, with CHG_ADDR = 2^PORT_ID_W-2 and MASK_ADDR = 2^PORT_ID_W-1:
  - Read 0..N_IN-1: synchronised value of input channel i.
  - Read CHG_ADDR: chg flags in bits [N_IN-1:0]; upper bits read 0.
  - Read MASK_ADDR: mask in bits [N_IN-1:0]; upper bits read 0.
  - Write 0..N_OUT-1: out_pins channel i.
  - Write CHG_ADDR: write-1-to-clear on bits [N_IN-1:0].
  - Write MASK_ADDR: mask <= wr_data[N_IN-1:0].
  - Unmapped reads return 0 and still pulse rd_valid. Unmapped writes are ignored.
- Input path: each channel passes through a SYNC_STAGES-deep flop chain. The value presented to reads is the last stage, so pin-to-readable latency is SYNC_STAGES cycles.
- Change detect:
  - A register holds the previous last-stage value.
  - chg[i] sets in any cycle where the last stage differs from the previous value in any bit.
  - A flag stays set until cleared by a write-1 to CHG_ADDR.
- Change detect after reset: prev clears to 0, so a nonzero pin value after reset sets chg. This is intended; firmware clears flags at boot.
- Set/clear collision: a new change event and a W1C on the same bit in the same cycle leaves the flag set (set wins).
- irq: irq = |(chg & mask), computed from registered state. It rises the cycle after chg or mask is updated and is never combinational from the strobes.
- Write timing: a write_strobe in cycle T updates the target register at the clk edge ending T, so out_pins shows the new value from T+1. Writes to other channels hold.
- Read timing:
  - A read_strobe in cycle T captures the addressed value, so rd_data is valid and rd_valid is high in T+1.
  - rd_valid is low whenever read_strobe was low in the previous cycle.
  - rd_data holds its last value when no read is in progress.
  - Reading CHG_ADDR does not clear flags.
- Simultaneous read and write in the same cycle:
  - Both are performed.
  - A read of the same address returns the pre-write value.
  - A read of CHG_ADDR during a W1C to CHG_ADDR returns the flags before the clear.
- Strobes are single-cycle pulses. A strobe held for k cycles is treated as k independent accesses.

Test Plan:
- Reset: pins nonzero, rst high for 2 cycles -> out_pins=0, rd_valid=0, irq=0. After rst falls, chg reflects nonzero inputs SYNC_STAGES+1 cycles later.
- Output write: write_strobe with port_id=1, wr_data=8'hA5 -> out_pins[15:8]=8'hA5 the next cycle and out_pins[7:0] unchanged. A write with port_id=5 changes nothing.
- Input read latency: set in_pins[7:0]=8'h3C, then read port 0 each cycle -> 8'h3C is first returned when the strobe is SYNC_STAGES cycles after the pin change, with rd_valid one cycle after each strobe. A read of port 7 returns 8'h00 with rd_valid=1.
- Interrupt flow:
  - Write MASK=8'h01, toggle channel 0 -> chg=8'h01 and irq=1.
  - Toggle channel 1 only -> chg=8'h03 and irq stays 1.
  - W1C 8'h01 -> chg=8'h02 and irq=0 the next cycle.
- Collisions:
  - W1C CHG in the same cycle a new channel-0 change is detected -> chg[0] stays 1.
  - Read and write of port 0 in the same cycle -> rd_data holds the old value.
- Mid-operation reset: assert rst in the same cycle as write_strobe to port 0 with wr_data=8'hFF -> out_pins stays 0, and rd_valid stays 0 for a concurrent read.

Source files
------------

// File: rtl/io_port_bank_if.sv
// Processor-side port bus for io_port_bank: address, strobes, write data and registered read data.
interface io_port_bank_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PORT_ID_W = 4
) ();

  logic [PORT_ID_W-1:0] port_id;
  logic                 write_strobe;
  logic                 read_strobe;
  logic [DATA_W-1:0]    wr_data;
  logic [DATA_W-1:0]    rd_data;
  logic                 rd_valid;

  modport master (
    output port_id,
    output write_strobe,
    output read_strobe,
    output wr_data,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  port_id,
    input  write_strobe,
    input  read_strobe,
    input  wr_data,
    output rd_data,
    output rd_valid
  );

endinterface

// File: rtl/io_port_bank.sv
// Addressed I/O port bank: synchronised inputs with change flags and maskable irq,
// latched outputs, registered single-cycle reads.
module io_port_bank #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned N_IN        = 2,
  parameter int unsigned N_OUT       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PORT_ID_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  io_port_bank_if.slave           bus,
  input  logic [N_IN*DATA_W-1:0]  in_pins,
  output logic [N_OUT*DATA_W-1:0] out_pins,
  output logic                    irq
);

  localparam logic [PORT_ID_W-1:0] ChgAddr  = {{(PORT_ID_W-1){1'b1}}, 1'b0};
  localparam logic [PORT_ID_W-1:0] MaskAddr = '1;
  localparam int unsigned          InW      = N_IN * DATA_W;

  logic [SYNC_STAGES-1:0][InW-1:0] sync_q;
  logic [InW-1:0]                  in_sync;
  logic [InW-1:0]                  prev_q;
  logic [N_IN-1:0]                 chg_q, chg_d, chg_evt, chg_clr;
  logic [N_IN-1:0]                 mask_q, mask_d;
  logic [N_OUT*DATA_W-1:0]         out_q, out_d;
  logic [DATA_W-1:0]               rd_mux, rd_data_q, rd_data_d;
  logic                            rd_valid_q;

  assign in_sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    chg_evt = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      chg_evt[i] = in_sync[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    out_d   = out_q;
    mask_d  = mask_q;
    chg_clr = '0;
    if (bus.write_strobe) begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (bus.port_id == PORT_ID_W'(i)) out_d[i*DATA_W +: DATA_W] = bus.wr_data;
      end
      if (bus.port_id == ChgAddr)  chg_clr = bus.wr_data[N_IN-1:0];
      if (bus.port_id == MaskAddr) mask_d  = bus.wr_data[N_IN-1:0];
    end
    // A fresh change event beats a same-cycle clear.
    chg_d = (chg_q & ~chg_clr) | chg_evt;
  end

  // Reads see pre-write register state, so same-cycle read/write returns the old value.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (bus.port_id == PORT_ID_W'(i)) rd_mux = in_sync[i*DATA_W +: DATA_W];
    end
    if (bus.port_id == ChgAddr)  rd_mux = DATA_W'(chg_q);
    if (bus.port_id == MaskAddr) rd_mux = DATA_W'(mask_q);
    rd_data_d = bus.read_strobe ? rd_mux : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= '0;
      chg_q      <= '0;
      mask_q     <= '0;
      out_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], in_pins};
      prev_q     <= in_sync;
      chg_q      <= chg_d;
      mask_q     <= mask_d;
      out_q      <= out_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= bus.read_strobe;
    end
  end

  assign out_pins     = out_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign irq          = |(chg_q & mask_q);

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: per-cycle reference model plus directed literal checks.
module tb_io_port_bank;

  localparam int unsigned DW = 8;
  localparam int unsigned NI = 2;
  localparam int unsigned NO = 2;
  localparam int unsigned SS = 2;
  localparam int unsigned PW = 4;
  localparam logic [PW-1:0] CHG = 4'd14;
  localparam logic [PW-1:0] MSK = 4'd15;

  logic           clk = 1'b0;
  logic           rst;
  logic [NI*DW-1:0] in_pins;
  logic [NO*DW-1:0] out_pins;
  logic           irq;

  io_port_bank_if #(.DATA_W(DW), .PORT_ID_W(PW)) bus ();

  io_port_bank #(
    .DATA_W     (DW),
    .N_IN       (NI),
    .N_OUT      (NO),
    .SYNC_STAGES(SS),
    .PORT_ID_W  (PW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .in_pins (in_pins),
    .out_pins(out_pins),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pin value becomes visible SS clock edges after it is sampled.
  logic [NI*DW-1:0] m_pipe[$];
  logic [NI*DW-1:0] m_prev;
  logic [NI*DW-1:0] m_seen;
  logic [NI-1:0]    m_chg, m_mask, m_evt, m_clr;
  logic [NO*DW-1:0] m_out;
  logic [DW-1:0]    m_rd;
  logic             m_rdv;

  function automatic logic [DW-1:0] m_read(input logic [PW-1:0] a, input logic [NI*DW-1:0] seen,
                                           input logic [NI-1:0] chg, input logic [NI-1:0] mask);
    int idx;
    idx = int'(a);
    if (idx < int'(NI)) return seen[idx*DW +: DW];
    if (a == CHG) return DW'(chg);
    if (a == MSK) return DW'(mask);
    return '0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pipe.delete();
      for (int i = 0; i < int'(SS); i++) m_pipe.push_back('0);
      m_prev = '0;
      m_chg  = '0;
      m_mask = '0;
      m_out  = '0;
      m_rd   = '0;
      m_rdv  = 1'b0;
    end else begin
      m_seen = m_pipe[0];
      for (int i = 0; i < int'(NI); i++) m_evt[i] = m_seen[i*DW +: DW] != m_prev[i*DW +: DW];
      m_rdv = bus.read_strobe;
      if (bus.read_strobe) m_rd = m_read(bus.port_id, m_seen, m_chg, m_mask);
      m_clr = '0;
      if (bus.write_strobe) begin
        if (int'(bus.port_id) < int'(NO)) m_out[int'(bus.port_id)*DW +: DW] = bus.wr_data;
        if (bus.port_id == CHG) m_clr = bus.wr_data[NI-1:0];
        if (bus.port_id == MSK) m_mask = bus.wr_data[NI-1:0];
      end
      m_chg  = (m_chg & ~m_clr) | m_evt;
      m_prev = m_seen;
      void'(m_pipe.pop_front());
      m_pipe.push_back(in_pins);
    end
    #1;
    check("model out_pins", 32'(out_pins), 32'(m_out));
    check("model rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
    check("model rd_data", 32'(bus.rd_data), 32'(m_rd));
    check("model irq", 32'(irq), 32'(|(m_chg & m_mask)));
  end

  task automatic wr(input logic [PW-1:0] a, input logic [DW-1:0] d);
    bus.port_id      = a;
    bus.wr_data      = d;
    bus.write_strobe = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
  endtask

  task automatic rd(input logic [PW-1:0] a, output logic [DW-1:0] d);
    bus.port_id     = a;
    bus.read_strobe = 1'b1;
    @(negedge clk);
    bus.read_strobe = 1'b0;
    d = bus.rd_data;
    check("rd_valid after strobe", 32'(bus.rd_valid), 32'd1);
  endtask

  task automatic rw(input logic [PW-1:0] a, input logic [DW-1:0] wd, output logic [DW-1:0] d);
    bus.port_id      = a;
    bus.wr_data      = wd;
    bus.write_strobe = 1'b1;
    bus.read_strobe  = 1'b1;
    @(negedge clk);
    bus.write_strobe = 1'b0;
    bus.read_strobe  = 1'b0;
    d = bus.rd_data;
  endtask

  logic [DW-1:0] r;
  logic [DW-1:0] lat[4];

  initial begin
    rst              = 1'b1;
    in_pins          = 16'h1234;
    bus.port_id      = '0;
    bus.wr_data      = '0;
    bus.write_strobe = 1'b0;
    bus.read_strobe  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset out_pins", 32'(out_pins), 32'h0);
    check("reset rd_valid", 32'(bus.rd_valid), 32'h0);
    check("reset irq", 32'(irq), 32'h0);
    rst = 1'b0;

    repeat (4) @(negedge clk);
    rd(CHG, r);       check("chg after reset", 32'(r), 32'h03);
    check("irq masked", 32'(irq), 32'h0);
    wr(CHG, 8'hFF);
    rd(CHG, r);       check("chg cleared", 32'(r), 32'h00);

    wr(4'd1, 8'hA5);  check("write ch1", 32'(out_pins), 32'hA500);
    wr(4'd5, 8'hFF);  check("unmapped write", 32'(out_pins), 32'hA500);
    wr(4'd0, 8'h3C);  check("write ch0", 32'(out_pins), 32'hA53C);

    in_pins = 16'h123C;
    for (int i = 0; i < 4; i++) rd(4'd0, lat[i]);
    check("latency rd0", 32'(lat[0]), 32'h34);
    check("latency rd1", 32'(lat[1]), 32'h34);
    check("latency rd2", 32'(lat[2]), 32'h3C);
    rd(4'd7, r);      check("unmapped read", 32'(r), 32'h00);
    wr(CHG, 8'hFF);
    rd(CHG, r);       check("chg clear 2", 32'(r), 32'h00);

    wr(MSK, 8'h01);
    in_pins = 16'h12C3;
    repeat (4) @(negedge clk);
    check("irq ch0", 32'(irq), 32'h1);
    rd(CHG, r);       check("chg ch0", 32'(r), 32'h01);
    in_pins = 16'hEDC3;
    repeat (4) @(negedge clk);
    rd(CHG, r);       check("chg both", 32'(r), 32'h03);
    check("irq held", 32'(irq), 32'h1);
    wr(CHG, 8'h01);
    check("irq after w1c", 32'(irq), 32'h0);
    rd(CHG, r);       check("chg after w1c", 32'(r), 32'h02);
    rd(MSK, r);       check("mask read", 32'(r), 32'h01);

    // Change on ch0 is detected two cycles after the pin moves; clear lands on that cycle.
    in_pins = 16'hED3C;
    repeat (2) @(negedge clk);
    wr(CHG, 8'h01);
    rd(CHG, r);       check("set wins", 32'(r), 32'h03);
    check("irq set wins", 32'(irq), 32'h1);

    rw(MSK, 8'h03, r); check("rw mask old", 32'(r), 32'h01);
    rd(MSK, r);        check("rw mask new", 32'(r), 32'h03);
    rw(CHG, 8'hFF, r); check("rw chg old", 32'(r), 32'h03);
    rd(CHG, r);        check("rw chg new", 32'(r), 32'h00);
    rw(4'd0, 8'h77, r); check("rw port0 read", 32'(r), 32'h3C);
    check("rw port0 write", 32'(out_pins), 32'hA577);

    rst              = 1'b1;
    bus.port_id      = 4'd0;
    bus.wr_data      = 8'hFF;
    bus.write_strobe = 1'b1;
    bus.read_strobe  = 1'b1;
    @(negedge clk);
    rst              = 1'b0;
    bus.write_strobe = 1'b0;
    bus.read_strobe  = 1'b0;
    check("midrst out_pins", 32'(out_pins), 32'h0);
    check("midrst rd_valid", 32'(bus.rd_valid), 32'h0);
    check("midrst irq", 32'(irq), 32'h0);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
